// File: rtl/upsampler_pkg.sv
// Shared types and constants for the horizontal x2 fp16 upsampling sequencer.
package upsampler_pkg;

    localparam int FP_W        = 16;
    localparam int KERNEL_TAPS = 7;

    localparam logic [FP_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP_W-1:0] FP16_Q025 = 16'h3400;
    localparam logic [FP_W-1:0] FP16_Q075 = 16'h3A00;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FLUSH = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    // Interpolation kernel for zero-stuffed x2 upsampling (odd taps land on stuffed zeros)
    localparam logic [FP_W-1:0] KERNEL_SH_H [KERNEL_TAPS] = '{
        FP16_Q025, FP16_ZERO, FP16_Q075, FP16_ZERO, FP16_Q075, FP16_ZERO, FP16_Q025
    };

    // Limit a requested row width to the largest supported width
    function automatic logic [15:0] clamp_width(input logic [15:0] w, input logic [15:0] max_w);
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/upsampler_h_sequencer_fp16_window_shift_reg.sv
// Sliding window register: taps[DEPTH-1] is the newest sample, taps[0] the oldest.
// clear zeroes the history; together with shift_en it starts a fresh window
// holding only din, so a new row can begin without a dead cycle.
module window_shift_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] taps [DEPTH]
);

    logic [WIDTH-1:0] tap_reg [DEPTH];

    // Shift toward the oldest tap; clear wipes the history, newest tap takes din on a shift
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (clear) begin
                    tap_reg[i] <= '0;
                end else if (shift_en) begin
                    tap_reg[i] <= tap_reg[i+1];
                end
            end
            if (shift_en) begin
                tap_reg[DEPTH-1] <= din;
            end else if (clear) begin
                tap_reg[DEPTH-1] <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_taps
            assign taps[gi] = tap_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/upsampler_h_sequencer_fp16.sv
// Row sequencer for the 7-tap horizontal x2 upsampling convolution.
// Zero-stuffs each input row (u[2k]=p[k], u[2k+1]=0), pads both borders with
// +0 and presents one 7-tap window per upsampled column. Pixel data is only moved.
module upsampler_h_sequencer_fp16
    import upsampler_pkg::*;
#(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int WINDOW_WIDTH = 7,
    parameter int MAX_WIDTH    = 2048
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [15:0]     width_i,
    input  logic [15:0]     height_i,
    input  logic [FP_W-1:0] pixel_i,
    input  logic            pixel_valid_i,
    output logic            pixel_ready_o,
    output logic [FP_W-1:0] window_o [1][7],
    output logic [FP_W-1:0] kernel_o [1][7],
    output logic [15:0]     col_o,
    output logic [15:0]     row_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            frame_done_o
);

    localparam int PIX_W = 1 + EXP_WIDTH + FRAC_WIDTH;

    generate
        if (WINDOW_WIDTH != 7) begin : g_bad_window
            $error("upsampler_h_sequencer_fp16: WINDOW_WIDTH must be 7");
        end
        if (PIX_W != FP_W) begin : g_bad_fp
            $error("upsampler_h_sequencer_fp16: 1+EXP_WIDTH+FRAC_WIDTH must be 16");
        end
        if (2 * MAX_WIDTH + 3 > 65535 || MAX_WIDTH < 1) begin : g_bad_max
            $error("upsampler_h_sequencer_fp16: 2*MAX_WIDTH+3 must fit in 16 bits");
        end
    endgenerate

    seq_state_t state_reg, state_next;
    logic [15:0] j_reg, j_next;            // index of the next u[] sample to shift in
    logic [15:0] row_reg, row_next;
    logic [15:0] width_reg, width_next;
    logic [15:0] height_reg, height_next;
    logic        valid_reg, valid_next;
    logic [15:0] col_reg, col_next;
    logic [15:0] row_out_reg, row_out_next;

    logic            shift_en;
    logic            shift_clear;
    logic [FP_W-1:0] shift_din;
    logic [FP_W-1:0] taps [7];

    logic [15:0] twice_w;
    logic [15:0] last_u;
    logic [15:0] flush_end;
    logic [15:0] height_last;

    assign twice_w     = width_reg << 1;
    assign last_u      = twice_w - 16'd1;
    assign flush_end   = twice_w + 16'd2;
    assign height_last = height_reg - 16'd1;

    window_shift_reg #(
        .WIDTH (FP_W),
        .DEPTH (7)
    ) u_window (
        .clk      (clk_i),
        .srst     (rst_i),
        .shift_en (shift_en),
        .clear    (shift_clear),
        .din      (shift_din),
        .taps     (taps)
    );

    // Next-state, counter and shift-control decode
    always_comb begin
        state_next   = state_reg;
        j_next       = j_reg;
        row_next     = row_reg;
        width_next   = width_reg;
        height_next  = height_reg;
        valid_next   = 1'b0;
        col_next     = col_reg;
        row_out_next = row_out_reg;
        shift_en     = 1'b0;
        shift_clear  = 1'b0;
        shift_din    = FP16_ZERO;

        case (state_reg)
            SEQ_IDLE: begin
                if (start_i) begin
                    width_next  = clamp_width(width_i, 16'(MAX_WIDTH));
                    height_next = height_i;
                    j_next      = 16'd0;
                    row_next    = 16'd0;
                    shift_clear = 1'b1;
                    if (width_i == 16'd0 || height_i == 16'd0) begin
                        state_next = SEQ_DONE;
                    end else begin
                        state_next = SEQ_RUN;
                    end
                end
            end
            SEQ_RUN: begin
                if (j_reg[0]) begin
                    // stuffed zero between input pixels, never stalls
                    shift_en  = 1'b1;
                    shift_din = FP16_ZERO;
                end else begin
                    shift_en  = pixel_valid_i;
                    shift_din = pixel_i;
                    // first sample of a row drops the previous row's history
                    shift_clear = pixel_valid_i && (j_reg == 16'd0);
                end
                if (shift_en) begin
                    j_next = j_reg + 16'd1;
                    if (j_reg == last_u) begin
                        state_next = SEQ_FLUSH;
                    end
                end
            end
            SEQ_FLUSH: begin
                // right border padding: three zeros complete the last windows
                shift_en  = 1'b1;
                shift_din = FP16_ZERO;
                if (j_reg == flush_end) begin
                    j_next = 16'd0;
                    if (row_reg == height_last) begin
                        state_next = SEQ_DONE;
                    end else begin
                        row_next   = row_reg + 16'd1;
                        state_next = SEQ_RUN;
                    end
                end else begin
                    j_next = j_reg + 16'd1;
                end
            end
            SEQ_DONE: begin
                // last window has been shown for a cycle; leave a clean window behind
                shift_clear = 1'b1;
                state_next  = SEQ_IDLE;
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase

        // a window is complete once three samples past its centre have arrived
        if (shift_en && j_reg >= 16'd3) begin
            valid_next   = 1'b1;
            col_next     = j_reg - 16'd3;
            row_out_next = row_reg;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= SEQ_IDLE;
            j_reg       <= 16'd0;
            row_reg     <= 16'd0;
            width_reg   <= 16'd0;
            height_reg  <= 16'd0;
            valid_reg   <= 1'b0;
            col_reg     <= 16'd0;
            row_out_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            j_reg       <= j_next;
            row_reg     <= row_next;
            width_reg   <= width_next;
            height_reg  <= height_next;
            valid_reg   <= valid_next;
            col_reg     <= col_next;
            row_out_reg <= row_out_next;
        end
    end

    assign pixel_ready_o = (state_reg == SEQ_RUN) && !j_reg[0];
    assign busy_o        = (state_reg == SEQ_RUN) || (state_reg == SEQ_FLUSH);
    assign frame_done_o  = (state_reg == SEQ_DONE);
    assign valid_o       = valid_reg;
    assign col_o         = col_reg;
    assign row_o         = row_out_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_out
            assign window_o[0][gi] = taps[gi];
            assign kernel_o[0][gi] = KERNEL_SH_H[gi];
        end
    endgenerate

endmodule
